// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a valid/ready load handshake and stall control.
// Supports MSB-first or LSB-first framing and back-to-back frames without idle gaps.
module piso_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             first;
    logic             last_bit;
    logic             load;
    logic             out_bit;

    assign last_bit    = (state == SHIFT) && (cnt == '0);
    assign done        = last_bit && shift_en;
    // Accepting on the done edge lets the next frame follow with no idle bubble.
    assign load_ready  = (state == IDLE) || done;
    assign load        = load_valid && load_ready;

    assign out_bit     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign sout        = (state == SHIFT) && out_bit;
    assign sout_valid  = (state == SHIFT);
    assign frame_start = (state == SHIFT) && first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            first <= 1'b0;
        end else if (load) begin
            state <= SHIFT;
            shreg <= din;
            cnt   <= CW'(WIDTH - 1);
            first <= 1'b1;
        end else if ((state == SHIFT) && shift_en) begin
            first <= 1'b0;
            if (cnt == '0) begin
                state <= IDLE;
                shreg <= '0;
            end else begin
                shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                cnt   <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: three instances (8-bit MSB-first, 8-bit LSB-first, 1-bit)
// share stimulus; a bit queue holds the expected serial stream of the selected instance.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       load_valid = 1'b0;
    logic       shift_en = 1'b1;

    logic [2:0] lr, so, sv, fs, dn;
    int unsigned sel = 0;

    logic o_lr, o_so, o_sv, o_fs, o_dn;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        exp_q[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(lr[0]), .shift_en(shift_en), .sout(so[0]),
        .sout_valid(sv[0]), .frame_start(fs[0]), .done(dn[0])
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(lr[1]), .shift_en(shift_en), .sout(so[1]),
        .sout_valid(sv[1]), .frame_start(fs[1]), .done(dn[1])
    );

    piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .din(din[0:0]), .load_valid(load_valid),
        .load_ready(lr[2]), .shift_en(shift_en), .sout(so[2]),
        .sout_valid(sv[2]), .frame_start(fs[2]), .done(dn[2])
    );

    always_comb begin
        o_lr = lr[sel];
        o_so = so[sel];
        o_sv = sv[sel];
        o_fs = fs[sel];
        o_dn = dn[sel];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive the inputs for the next edge and settle combinational outputs.
    task automatic cycle(input logic lv, input logic [7:0] d, input logic se);
        @(negedge clk);
        load_valid = lv;
        din        = d;
        shift_en   = se;
        #1;
    endtask

    task automatic push_word(input logic [7:0] w, input int unsigned width, input bit msb);
        for (int unsigned i = 0; i < width; i++)
            exp_q.push_back(msb ? w[width-1-i] : w[i]);
    endtask

    task automatic check_bit(input string tag, input logic e_fs, input logic e_dn, input logic e_lr);
        logic e_bit;
        e_bit = (exp_q.size() != 0) ? exp_q[0] : 1'bx;
        chk({tag, "_valid"}, o_sv, 1);
        chk({tag, "_sout"}, o_so, e_bit);
        chk({tag, "_fs"}, o_fs, e_fs);
        chk({tag, "_done"}, o_dn, e_dn);
        chk({tag, "_ready"}, o_lr, e_lr);
        if (shift_en && exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, o_sv, 0);
        chk({tag, "_sout"}, o_so, 0);
        chk({tag, "_fs"}, o_fs, 0);
        chk({tag, "_done"}, o_dn, 0);
        chk({tag, "_ready"}, o_lr, 1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        // Reset state on every instance
        cycle(0, 8'h00, 1);
        for (int unsigned s = 0; s < 3; s++) begin
            sel = s;
            #0 check_idle($sformatf("rst%0d", s));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // MSB-first A5, din scrambled during the frame
        sel = 0;
        cycle(1, 8'hA5, 1);
        chk("a5_ready_idle", o_lr, 1);
        push_word(8'hA5, 8, 1'b1);
        for (int unsigned i = 0; i < 8; i++) begin
            cycle(0, 8'($urandom), 1);
            check_bit($sformatf("a5_b%0d", i), i == 0, i == 7, i == 7);
        end
        cycle(0, 8'h00, 1);
        check_idle("a5_end");

        // LSB-first 01
        reset_pulse();
        sel = 1;
        cycle(1, 8'h01, 1);
        push_word(8'h01, 8, 1'b0);
        for (int unsigned i = 0; i < 8; i++) begin
            cycle(0, 8'hFF, 1);
            check_bit($sformatf("lsb_b%0d", i), i == 0, i == 7, i == 7);
        end
        cycle(0, 8'h00, 1);
        check_idle("lsb_end");

        // Back-to-back F0 then 0F
        reset_pulse();
        sel = 0;
        cycle(1, 8'hF0, 1);
        push_word(8'hF0, 8, 1'b1);
        push_word(8'h0F, 8, 1'b1);
        for (int unsigned i = 0; i < 16; i++) begin
            cycle(i < 8, 8'h0F, 1);
            check_bit($sformatf("b2b_b%0d", i), (i == 0) || (i == 8),
                      (i == 7) || (i == 15), (i == 7) || (i == 15));
        end
        cycle(0, 8'h00, 1);
        check_idle("b2b_end");

        // Stall three cycles on bit 3 of C3
        reset_pulse();
        cycle(1, 8'hC3, 1);
        push_word(8'hC3, 8, 1'b1);
        for (int unsigned k = 0; k < 11; k++) begin
            cycle(0, 8'h3C, !(k >= 3 && k <= 5));
            check_bit($sformatf("stall_k%0d", k), k == 0, k == 10, k == 10);
        end
        chk("stall_sb_empty", exp_q.size(), 0);
        cycle(0, 8'h00, 1);
        check_idle("stall_end");

        // Asynchronous reset at bit 4, then a clean frame
        reset_pulse();
        cycle(1, 8'hFF, 1);
        push_word(8'hFF, 8, 1'b1);
        for (int unsigned i = 0; i < 5; i++) begin
            cycle(0, 8'h00, 1);
            check_bit($sformatf("abort_b%0d", i), i == 0, 1'b0, 1'b0);
        end
        #1 rst_n = 1'b0;
        #1 check_idle("abort_async");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 8'h55, 1);
        chk("post_rst_ready", o_lr, 1);
        push_word(8'h55, 8, 1'b1);
        for (int unsigned i = 0; i < 8; i++) begin
            cycle(0, 8'hAA, 1);
            check_bit($sformatf("p55_b%0d", i), i == 0, i == 7, i == 7);
        end
        cycle(0, 8'h00, 1);
        check_idle("p55_end");

        // WIDTH=1: single-cycle frame, then one stalled on its only bit
        reset_pulse();
        sel = 2;
        cycle(1, 8'h01, 1);
        push_word(8'h01, 1, 1'b1);
        cycle(0, 8'h00, 1);
        check_bit("w1_a", 1'b1, 1'b1, 1'b1);
        cycle(1, 8'h01, 1);
        check_idle("w1_idle");
        push_word(8'h01, 1, 1'b1);
        cycle(0, 8'h00, 0);
        check_bit("w1_stall", 1'b1, 1'b0, 1'b0);
        cycle(0, 8'h00, 1);
        check_bit("w1_go", 1'b1, 1'b1, 1'b1);
        cycle(0, 8'h00, 1);
        check_idle("w1_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, number of bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port din  input  WIDTH  parallel word to transmit.
REQ-006 The block SHALL have port load_valid  input  1  din is valid and offered for transmission.
REQ-007 The block SHALL have port load_ready  output  1  block accepts din on this edge if load_valid=1.
REQ-008 The block SHALL have port shift_en  input  1  advance one bit this cycle; 0 = stall, hold sout.
REQ-009 The block SHALL have port sout  output  1  serial data bit currently presented.
REQ-010 The block SHALL have port sout_valid  output  1  sout carries a frame bit.
REQ-011 The block SHALL have port frame_start  output  1  high while the first bit of a frame is presented.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on the edge that consumes the last bit.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT; internal registers: shift register shreg[WIDTH], bit counter cnt (ceil(log2(WIDTH+1)) bits), first-bit flag.
REQ-014 Handshake: a load SHALL occur on a rising edge where load_valid=1 and load_ready=1; din is captured into shreg, cnt <= WIDTH-1, first-bit flag set, state <= SHIFT.
REQ-015 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only when cnt==0 and shift_en==1; 0 otherwise (combinational from state, cnt, shift_en).
REQ-016 In SHIFT, sout SHALL equal shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0; sout_valid SHALL be 1.
REQ-017 In IDLE, sout SHALL be 0 and sout_valid SHALL be 0.
REQ-018 In SHIFT with shift_en=1 and cnt>0, shreg SHALL shift one position toward the output end (zero fill), cnt SHALL decrement by 1, first-bit flag SHALL clear.
REQ-019 In SHIFT with shift_en=0, shreg, cnt, flag and state SHALL hold; sout/sout_valid/frame_start unchanged.
REQ-020 frame_start SHALL equal (state==SHIFT) AND first-bit flag; it stays high through stalls on the first bit.
REQ-021 done SHALL be 1 exactly when state==SHIFT, cnt==0 and shift_en==1; never in IDLE.
REQ-022 On the done edge with load_valid=1, the block SHALL load the new word and remain in SHIFT (back-to-back frames, no idle bubble); with load_valid=0 it SHALL go to IDLE.
REQ-023 Latency: first bit of a loaded word SHALL appear on sout the cycle after the load edge; a frame with no stalls occupies exactly WIDTH cycles.
REQ-024 WIDTH=1: every SHIFT cycle is both first and last bit; frame_start and done SHALL assert together when shift_en=1.
REQ-025 din changes while in SHIFT and not loading SHALL have no effect on the frame in progress.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, shreg=0, cnt=0, flag=0, so sout=0, sout_valid=0, frame_start=0, done=0, load_ready=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame; no done pulse is produced and the partial frame is not resumed after release.
REQ-028 After rst_n deasserts, the first load SHALL be accepted on the first rising edge with load_valid=1.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, shift_en=1, load din=8'hA5 -> sout=1,0,1,0,0,1,0,1 over 8 cycles, frame_start on cycle 1 only, done on cycle 8, then IDLE.
REQ-030 MSB_FIRST=0, load 8'h01 -> sout=1,0,0,0,0,0,0,0; load_ready=0 during cycles 1-7.
REQ-031 Back-to-back: load 8'hF0 then hold load_valid=1 with din=8'h0F -> 16 consecutive valid bits 11110000 00001111, second frame_start in cycle 9, sout_valid never drops.
REQ-032 Stall: load 8'hC3, drive shift_en=0 for 3 cycles at bit 3 -> bit 3 (0) held 4 cycles, frame length 11 cycles, done asserts once.
REQ-033 Reset mid-frame: assert rst_n=0 at bit 4 between clock edges -> sout_valid and sout drop to 0 without a clock edge, no done; after release load 8'h55 transmits cleanly.
REQ-034 WIDTH=1: load 1'b1 -> single cycle with sout=1, frame_start=1, done=1, load_ready=1.
